mdu_sequencer: RTL

- Iterative multiply/divide unit with controller for the RV32M extension.
- Accepts one M-type instruction from decode: funct3 plus two operands. Runs a radix-2 shift-add multiplier or restoring divider over XLEN cycles.
- Stalls the pipeline while busy.
- Sits beside the ALU. The ALU control path routes M-type ops here instead of to the single-cycle ALU.

---
 rtl/mdu_sequencer_if.sv | 24 ++
 rtl/mdu_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer_if.sv
// Decode-side request / result bundle for the iterative RV32M multiply-divide unit.
interface mdu_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            MDU_Start_In;
  logic            MDU_Flush_In;
  logic [2:0]      MDU_Funct3_InBUS;
  logic [XLEN-1:0] MDU_OperandA_InBUS;
  logic [XLEN-1:0] MDU_OperandB_InBUS;
  logic            MDU_Busy_Out;
  logic            MDU_Stall_Out;
  logic            MDU_Done_Out;
  logic [XLEN-1:0] MDU_Result_OutBUS;

  modport master (
    output MDU_Start_In, MDU_Flush_In, MDU_Funct3_InBUS, MDU_OperandA_InBUS, MDU_OperandB_InBUS,
    input  MDU_Busy_Out, MDU_Stall_Out, MDU_Done_Out, MDU_Result_OutBUS
  );

  modport slave (
    input  MDU_Start_In, MDU_Flush_In, MDU_Funct3_InBUS, MDU_OperandA_InBUS, MDU_OperandB_InBUS,
    output MDU_Busy_Out, MDU_Stall_Out, MDU_Done_Out, MDU_Result_OutBUS
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M unit: radix-2 shift-add multiplier and restoring divider sharing one
// accumulator pair, sequenced IDLE -> PREP -> CALC (XLEN cycles) -> FIX -> DONE.
module mdu_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 6
) (
  input  logic            MDU_CLOCK_50,
  input  logic            MDU_RESET_InLow,
  mdu_sequencer_if.slave  bus
);

  localparam int unsigned PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] acc_hi, acc_lo, op_q;
  logic [CNTW-1:0] cnt;
  logic            sign_q;
  logic            busy, done;
  logic [XLEN-1:0] result;

  // Operand classification and magnitudes, valid while in PREP
  logic            is_div, is_rem, a_signed, b_signed, neg_a, neg_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;
  always_comb begin
    is_div   = f3_q[2];
    is_rem   = f3_q[2] & f3_q[1];
    a_signed = (f3_q == F_MULH) || (f3_q == F_MULHSU) || (f3_q == F_DIV) || (f3_q == F_REM);
    b_signed = (f3_q == F_MULH) || (f3_q == F_DIV) || (f3_q == F_REM);
    neg_a    = a_signed & a_q[XLEN-1];
    neg_b    = b_signed & b_q[XLEN-1];
    mag_a    = neg_a ? (~a_q + XLEN'(1)) : a_q;
    mag_b    = neg_b ? (~b_q + XLEN'(1)) : b_q;
    div_zero = is_div & (b_q == '0);
    div_ovf  = is_div & ~f3_q[0] & (a_q == MIN_NEG) & (b_q == '1);
    if (div_zero) spec_res = is_rem ? a_q : '1;
    else          spec_res = is_rem ? '0 : MIN_NEG;
  end

  // One iteration step of each algorithm
  logic [XLEN:0] mul_sum, div_shift, div_trial;
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, {XLEN{acc_lo[0]}} & op_q};
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_trial = div_shift - {1'b0, op_q};
  end

  // Sign fix-up and field selection for the FIX state
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, res_sel;
  always_comb begin
    prod_fix = sign_q ? (~{acc_hi, acc_lo} + PW'(1)) : {acc_hi, acc_lo};
    quo_fix  = sign_q ? (~acc_lo + XLEN'(1)) : acc_lo;
    rem_fix  = sign_q ? (~acc_hi + XLEN'(1)) : acc_hi;
    if (!is_div) res_sel = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
    else         res_sel = is_rem ? rem_fix : quo_fix;
  end

  always_ff @(posedge MDU_CLOCK_50 or negedge MDU_RESET_InLow) begin
    if (!MDU_RESET_InLow) begin
      state  <= S_IDLE;
      f3_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      op_q   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.MDU_Start_In && !bus.MDU_Flush_In) begin
            f3_q  <= bus.MDU_Funct3_InBUS;
            a_q   <= bus.MDU_OperandA_InBUS;
            b_q   <= bus.MDU_OperandB_InBUS;
            busy  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          if (bus.MDU_Flush_In) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt    <= CNTW'(XLEN);
            sign_q <= is_rem ? neg_a : (neg_a ^ neg_b);
            acc_hi <= '0;
            acc_lo <= is_div ? mag_a : mag_b;
            op_q   <= is_div ? mag_b : mag_a;
            if (div_zero || div_ovf) begin
              result <= spec_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.MDU_Flush_In) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            // Divider keeps the quotient in acc_lo and the partial remainder in acc_hi
            if (is_div) begin
              if (!div_trial[XLEN]) begin
                acc_hi <= div_trial[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
              end else begin
                acc_hi <= div_shift[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
              end
            end else begin
              acc_hi <= mul_sum[XLEN:1];
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
            cnt <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.MDU_Flush_In) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            result <= res_sel;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.MDU_Busy_Out      = busy;
  assign bus.MDU_Done_Out      = done;
  assign bus.MDU_Result_OutBUS = result;
  // Hold decode from the request cycle until the result is presented
  assign bus.MDU_Stall_Out     = (busy | (bus.MDU_Start_In & (state == S_IDLE))) & ~done;

endmodule
